// File: rtl/axi_wr_arbiter_if.sv
// Requester-side and PCIe-side AXI write channels around axi_wr_arbiter.
// slave is the arbiter's view; master is the view of whatever drives it (requesters + PCIe block).
interface axi_wr_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 128
);
    localparam int SRC_W  = $clog2(NUM_REQ);
    localparam int MID_W  = ID_W + SRC_W;
    localparam int STRB_W = DATA_W / 8;

    // Every channel: a beat moves on the rising clk edge where valid && ready are both high;
    // the source keeps valid and payload stable until then, and ready may follow valid combinationally.
    logic [NUM_REQ-1:0]        s_awvalid;
    logic [NUM_REQ-1:0]        s_awready;
    logic [NUM_REQ*ID_W-1:0]   s_awid;
    logic [NUM_REQ*ADDR_W-1:0] s_awaddr;
    logic [NUM_REQ*4-1:0]      s_awlen;
    logic [NUM_REQ*3-1:0]      s_awsize;
    logic [NUM_REQ*2-1:0]      s_awburst;
    logic [NUM_REQ-1:0]        s_wvalid;
    logic [NUM_REQ-1:0]        s_wready;
    logic [NUM_REQ*DATA_W-1:0] s_wdata;
    logic [NUM_REQ*STRB_W-1:0] s_wstrb;
    logic [NUM_REQ-1:0]        s_wlast;
    logic [NUM_REQ-1:0]        s_bvalid;
    logic [NUM_REQ-1:0]        s_bready;
    logic [ID_W-1:0]           s_bid;
    logic [1:0]                s_bresp;

    logic                      m_awvalid;
    logic                      m_awready;
    logic [MID_W-1:0]          m_awid;
    logic [ADDR_W-1:0]         m_awaddr;
    logic [3:0]                m_awlen;
    logic [2:0]                m_awsize;
    logic [1:0]                m_awburst;
    logic                      m_wvalid;
    logic                      m_wready;
    logic [DATA_W-1:0]         m_wdata;
    logic [STRB_W-1:0]         m_wstrb;
    logic                      m_wlast;
    logic                      m_bvalid;
    logic                      m_bready;
    logic [MID_W-1:0]          m_bid;
    logic [1:0]                m_bresp;

    logic                      aw_state_dbg;  // 1 while the AW FSM holds a grant

    modport slave (
        input  s_awvalid, s_awid, s_awaddr, s_awlen, s_awsize, s_awburst,
        output s_awready,
        input  s_wvalid, s_wdata, s_wstrb, s_wlast,
        output s_wready,
        output s_bvalid, s_bid, s_bresp,
        input  s_bready,
        output m_awvalid, m_awid, m_awaddr, m_awlen, m_awsize, m_awburst,
        input  m_awready,
        output m_wvalid, m_wdata, m_wstrb, m_wlast,
        input  m_wready,
        input  m_bvalid, m_bid, m_bresp,
        output m_bready,
        output aw_state_dbg
    );

    modport master (
        output s_awvalid, s_awid, s_awaddr, s_awlen, s_awsize, s_awburst,
        input  s_awready,
        output s_wvalid, s_wdata, s_wstrb, s_wlast,
        input  s_wready,
        input  s_bvalid, s_bid, s_bresp,
        output s_bready,
        input  m_awvalid, m_awid, m_awaddr, m_awlen, m_awsize, m_awburst,
        output m_awready,
        input  m_wvalid, m_wdata, m_wstrb, m_wlast,
        output m_wready,
        output m_bvalid, m_bid, m_bresp,
        input  m_bready,
        input  aw_state_dbg
    );
endinterface

// File: rtl/axi_wr_arbiter.sv
// Round-robin AW arbiter for the shared PCIe write port; W follows AW-grant order via a small
// order FIFO and B is routed back by the source tag carried in the upper ID bits.
module axi_wr_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int ID_W      = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 128,
    parameter int ORD_DEPTH = 4
) (
    input logic             clk,
    input logic             rst,
    axi_wr_arbiter_if.slave bus
);
    localparam int SRC_W  = $clog2(NUM_REQ);
    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = $clog2(ORD_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } aw_state_t;

    aw_state_t        state_q, state_d;
    logic [SRC_W-1:0] grant_q, grant_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0] pick_idx, cand;
    logic             pick_found;
    logic             aw_hs;

    logic [SRC_W-1:0] ord_mem [ORD_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             ord_full, ord_empty, ord_pop;
    logic [SRC_W-1:0] ord_head;
    logic [SRC_W-1:0] b_src;

    logic [ID_W-1:0]   aw_id_a    [NUM_REQ];
    logic [ADDR_W-1:0] aw_addr_a  [NUM_REQ];
    logic [3:0]        aw_len_a   [NUM_REQ];
    logic [2:0]        aw_size_a  [NUM_REQ];
    logic [1:0]        aw_burst_a [NUM_REQ];
    logic [DATA_W-1:0] w_data_a   [NUM_REQ];
    logic [STRB_W-1:0] w_strb_a   [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign aw_id_a[i]    = bus.s_awid[i*ID_W +: ID_W];
        assign aw_addr_a[i]  = bus.s_awaddr[i*ADDR_W +: ADDR_W];
        assign aw_len_a[i]   = bus.s_awlen[i*4 +: 4];
        assign aw_size_a[i]  = bus.s_awsize[i*3 +: 3];
        assign aw_burst_a[i] = bus.s_awburst[i*2 +: 2];
        assign w_data_a[i]   = bus.s_wdata[i*DATA_W +: DATA_W];
        assign w_strb_a[i]   = bus.s_wstrb[i*STRB_W +: STRB_W];
    end

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = SRC_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!pick_found && bus.s_awvalid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign aw_hs = (state_q == GRANT) && bus.s_awvalid[grant_q] && bus.m_awready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_found && !ord_full) begin
                    grant_d = pick_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Grant is held until its handshake; m_awvalid is never withdrawn by the arbiter.
                if (aw_hs) begin
                    state_d  = IDLE;
                    rr_ptr_d = (int'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + SRC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.aw_state_dbg = (state_q == GRANT);

    always_comb begin
        bus.m_awvalid = 1'b0;
        bus.s_awready = '0;
        bus.m_awid    = {grant_q, aw_id_a[grant_q]};
        bus.m_awaddr  = aw_addr_a[grant_q];
        bus.m_awlen   = aw_len_a[grant_q];
        bus.m_awsize  = aw_size_a[grant_q];
        bus.m_awburst = aw_burst_a[grant_q];
        if (state_q == GRANT) begin
            bus.m_awvalid          = bus.s_awvalid[grant_q];
            bus.s_awready[grant_q] = bus.m_awready;
        end
    end

    // Order FIFO of granted sources; W beats drain strictly in AW-grant order.
    assign ord_full  = (count_q == CNT_W'(ORD_DEPTH));
    assign ord_empty = (count_q == '0);
    assign ord_head  = ord_mem[rd_ptr_q];
    assign ord_pop   = !ord_empty && bus.s_wvalid[ord_head] && bus.m_wready && bus.s_wlast[ord_head];

    always_ff @(posedge clk) begin
        if (aw_hs) begin
            ord_mem[wr_ptr_q] <= grant_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (aw_hs) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (ord_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({aw_hs, ord_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        bus.m_wvalid = !ord_empty && bus.s_wvalid[ord_head];
        bus.m_wdata  = w_data_a[ord_head];
        bus.m_wstrb  = w_strb_a[ord_head];
        bus.m_wlast  = bus.s_wlast[ord_head];
        bus.s_wready = '0;
        bus.s_wready[ord_head] = !ord_empty && bus.m_wready;
    end

    // Tags beyond NUM_REQ (only reachable when NUM_REQ = 3) are accepted and dropped.
    assign b_src = bus.m_bid[ID_W +: SRC_W];

    always_comb begin
        bus.s_bvalid = '0;
        bus.m_bready = 1'b1;
        if (int'(b_src) < NUM_REQ) begin
            bus.s_bvalid[b_src] = bus.m_bvalid;
            bus.m_bready        = bus.s_bready[b_src];
        end
    end

    assign bus.s_bid   = bus.m_bid[ID_W-1:0];
    assign bus.s_bresp = bus.m_bresp;
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter with two requesters; each scenario checks its own results.
module tb_axi_wr_arbiter;
    localparam int NUM_REQ   = 2;
    localparam int ID_W      = 4;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 128;
    localparam int ORD_DEPTH = 4;
    localparam int MID_W     = ID_W + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [DATA_W-1:0] exp_q[$];

    logic [ID_W-1:0]   aw_id   [2];
    logic [ADDR_W-1:0] aw_addr [2];
    logic [3:0]        aw_len  [2];
    logic [DATA_W-1:0] w_data  [2];

    always #5 clk = ~clk;

    axi_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    axi_wr_arbiter #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ORD_DEPTH(ORD_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    assign bus.s_awid    = {aw_id[1], aw_id[0]};
    assign bus.s_awaddr  = {aw_addr[1], aw_addr[0]};
    assign bus.s_awlen   = {aw_len[1], aw_len[0]};
    assign bus.s_awsize  = {3'd4, 3'd4};
    assign bus.s_awburst = {2'b01, 2'b01};
    assign bus.s_wdata   = {w_data[1], w_data[0]};
    assign bus.s_wstrb   = '1;

    // ---------------- clock/reset and driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.s_awvalid = '0;
        bus.s_wvalid  = '0;
        bus.s_wlast   = '0;
        bus.s_bready  = '0;
        bus.m_awready = 1'b0;
        bus.m_wready  = 1'b0;
        bus.m_bvalid  = 1'b0;
        bus.m_bid     = '0;
        bus.m_bresp   = '0;
        aw_id[0] = '0;  aw_id[1] = '0;
        aw_addr[0] = '0; aw_addr[1] = '0;
        aw_len[0] = '0; aw_len[1] = '0;
        w_data[0] = '0; w_data[1] = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        bus.s_awvalid = 2'b11;
        bus.s_wvalid  = 2'b11;
        bus.m_awready = 1'b1;
        bus.m_wready  = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({bus.m_awvalid, bus.m_wvalid, bus.s_awready, bus.s_wready, bus.s_bvalid, bus.aw_state_dbg} !== 9'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got awv=%0b wv=%0b awr=%0b wr=%0b bv=%0b st=%0b want all 0",
                     bus.m_awvalid, bus.m_wvalid, bus.s_awready, bus.s_wready, bus.s_bvalid, bus.aw_state_dbg);
        end
        idle_inputs();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        aw_id[0] = 4'h0; aw_addr[0] = 32'h0; aw_len[0] = 4'd1;
        bus.s_awvalid = 2'b01;
        bus.m_awready = 1'b1;
        bus.m_wready  = 1'b1;
        tick();
        n_cmp++;
        if ({bus.m_awvalid, bus.m_awid, bus.m_awaddr, bus.m_awlen, bus.m_awsize, bus.m_awburst} !==
            {1'b1, 5'h00, 32'h0, 4'd1, 3'd4, 2'b01}) begin
            n_bad++;
            $display("FAIL single_aw: got v=%0b id=%0h addr=%0h len=%0d size=%0d burst=%0d want v=1 id=0 addr=0 len=1 size=4 burst=1",
                     bus.m_awvalid, bus.m_awid, bus.m_awaddr, bus.m_awlen, bus.m_awsize, bus.m_awburst);
        end
        n_cmp++;
        if ({bus.s_awready, bus.s_wready} !== 4'b01_00) begin
            n_bad++;
            $display("FAIL single_readies: got awready=%0b wready=%0b want 01/00", bus.s_awready, bus.s_wready);
        end
        tick();
        bus.s_awvalid = 2'b00;
        w_data[0] = {4{32'h01234567}};
        bus.s_wvalid = 2'b01;
        bus.s_wlast  = 2'b00;
        #1;
        n_cmp++;
        if ({bus.m_wvalid, bus.m_wlast, bus.s_wready, bus.m_wdata} !== {1'b1, 1'b0, 2'b01, {4{32'h01234567}}}) begin
            n_bad++;
            $display("FAIL single_beat0: got v=%0b last=%0b wready=%0b data=%0h want v=1 last=0 wready=01 data=%0h",
                     bus.m_wvalid, bus.m_wlast, bus.s_wready, bus.m_wdata, {4{32'h01234567}});
        end
        tick();
        bus.s_wlast = 2'b01;
        #1;
        n_cmp++;
        if ({bus.m_wvalid, bus.m_wlast, bus.s_wready} !== 4'b11_01) begin
            n_bad++;
            $display("FAIL single_beat1: got v=%0b last=%0b wready=%0b want v=1 last=1 wready=01",
                     bus.m_wvalid, bus.m_wlast, bus.s_wready);
        end
        tick();
        n_cmp++;
        if ({bus.m_wvalid, bus.s_wready} !== 3'b0_00) begin
            n_bad++;
            $display("FAIL single_drained: got wvalid=%0b wready=%0b want 0/00", bus.m_wvalid, bus.s_wready);
        end
        bus.s_wvalid = 2'b00;
        bus.s_wlast  = 2'b00;
        bus.m_bvalid = 1'b1;
        bus.m_bid    = 5'h00;
        bus.m_bresp  = 2'b00;
        bus.s_bready = 2'b01;
        #1;
        n_cmp++;
        if ({bus.s_bvalid, bus.s_bresp, bus.m_bready} !== 5'b01_00_1) begin
            n_bad++;
            $display("FAIL single_b: got bvalid=%0b bresp=%0d bready=%0b want 01/0/1", bus.s_bvalid, bus.s_bresp, bus.m_bready);
        end
        tick();
        bus.m_bvalid = 1'b0;
        bus.s_bready = 2'b00;
    endtask

    task automatic test_contention();
        int rem0 = 2;
        int rem1 = 2;
        int hs   = 0;
        int got  = 0;
        int wc0  = 0;
        int wc1  = 0;
        do_reset();
        aw_id[0] = 4'h3; aw_id[1] = 4'h9;
        aw_addr[0] = 32'h1000; aw_addr[1] = 32'h2000;
        bus.m_awready = 1'b1;
        exp_q.delete();
        exp_q.push_back(DATA_W'(5'h03));
        exp_q.push_back(DATA_W'(5'h19));
        exp_q.push_back(DATA_W'(5'h03));
        exp_q.push_back(DATA_W'(5'h19));
        bus.s_awvalid = 2'b11;
        for (int c = 0; c < 20 && hs < 4; c++) begin
            tick();
            bus.s_awvalid = {rem1 > 0, rem0 > 0};
            #1;
            if (bus.m_awvalid && bus.m_awready) begin
                n_cmp++;
                if (DATA_W'(bus.m_awid) !== exp_q[0]) begin
                    n_bad++;
                    $display("FAIL contention_grant%0d: got awid=%0h want %0h", hs, bus.m_awid, exp_q[0]);
                end
                void'(exp_q.pop_front());
                hs++;
                if (bus.s_awready[0]) rem0--;
                if (bus.s_awready[1]) rem1--;
            end
        end
        n_cmp++;
        if (hs != 4) begin
            n_bad++;
            $display("FAIL contention_aw_count: got %0d handshakes want 4", hs);
        end
        tick();
        bus.s_awvalid = 2'b00;

        exp_q.delete();
        exp_q.push_back(DATA_W'(8'h00));
        exp_q.push_back(DATA_W'(8'h10));
        exp_q.push_back(DATA_W'(8'h01));
        exp_q.push_back(DATA_W'(8'h11));
        bus.s_wvalid = 2'b11;
        bus.s_wlast  = 2'b11;
        bus.m_wready = 1'b1;
        for (int c = 0; c < 20 && got < 4; c++) begin
            w_data[0] = DATA_W'(wc0);
            w_data[1] = DATA_W'(16 + wc1);
            #1;
            if (bus.m_wvalid && bus.m_wready) begin
                n_cmp++;
                if (bus.m_wdata !== exp_q[0]) begin
                    n_bad++;
                    $display("FAIL contention_wbeat%0d: got data=%0h want %0h", got, bus.m_wdata, exp_q[0]);
                end
                void'(exp_q.pop_front());
                got++;
                if (bus.s_wready[0]) wc0++;
                if (bus.s_wready[1]) wc1++;
            end
            tick();
        end
        n_cmp++;
        if ({bus.m_wvalid, bus.s_wready} !== 3'b0_00 || got != 4) begin
            n_bad++;
            $display("FAIL contention_w_done: got beats=%0d wvalid=%0b wready=%0b want 4/0/00", got, bus.m_wvalid, bus.s_wready);
        end
        idle_inputs();
    endtask

    task automatic test_early_w();
        do_reset();
        w_data[1] = DATA_W'(8'hAB);
        bus.s_wvalid  = 2'b10;
        bus.s_wlast   = 2'b10;
        bus.m_wready  = 1'b1;
        bus.m_awready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++;
            if ({bus.s_wready, bus.m_wvalid} !== 3'b00_0) begin
                n_bad++;
                $display("FAIL early_w_stall%0d: got wready=%0b wvalid=%0b want 00/0", c, bus.s_wready, bus.m_wvalid);
            end
            tick();
        end
        aw_id[1] = 4'h2; aw_addr[1] = 32'h100; aw_len[1] = 4'd0;
        bus.s_awvalid = 2'b10;
        tick();
        n_cmp++;
        if ({bus.s_awready, bus.s_wready, bus.m_wvalid} !== 5'b10_00_0) begin
            n_bad++;
            $display("FAIL early_w_hs_cycle: got awready=%0b wready=%0b wvalid=%0b want 10/00/0",
                     bus.s_awready, bus.s_wready, bus.m_wvalid);
        end
        tick();
        bus.s_awvalid = 2'b00;
        #1;
        n_cmp++;
        if ({bus.s_wready, bus.m_wvalid, bus.m_wdata} !== {2'b10, 1'b1, DATA_W'(8'hAB)}) begin
            n_bad++;
            $display("FAIL early_w_release: got wready=%0b wvalid=%0b data=%0h want 10/1/ab",
                     bus.s_wready, bus.m_wvalid, bus.m_wdata);
        end
        tick();
        n_cmp++;
        if (bus.s_wready !== 2'b00) begin
            n_bad++;
            $display("FAIL early_w_popped: got wready=%0b want 00", bus.s_wready);
        end
        idle_inputs();
    endtask

    task automatic test_fifo_full();
        int rem0 = 3;
        int rem1 = 2;
        int hs   = 0;
        int hs2  = 0;
        logic popped = 1'b0;
        do_reset();
        aw_id[0] = 4'hA; aw_id[1] = 4'hB;
        bus.m_awready = 1'b1;
        bus.m_wready  = 1'b0;
        bus.s_awvalid = 2'b11;
        for (int c = 0; c < 14; c++) begin
            tick();
            bus.s_awvalid = {rem1 > 0, rem0 > 0};
            #1;
            if (bus.m_awvalid && bus.m_awready) begin
                hs++;
                if (bus.s_awready[0]) rem0--;
                if (bus.s_awready[1]) rem1--;
            end
        end
        n_cmp++;
        if (hs != 4) begin
            n_bad++;
            $display("FAIL full_aw_count: got %0d handshakes want 4", hs);
        end
        n_cmp++;
        if ({bus.m_awvalid, bus.s_awready, bus.aw_state_dbg} !== 4'b0_00_0) begin
            n_bad++;
            $display("FAIL full_held: got awvalid=%0b awready=%0b st=%0b want 0/00/0",
                     bus.m_awvalid, bus.s_awready, bus.aw_state_dbg);
        end
        w_data[0] = DATA_W'(8'h55);
        bus.s_wvalid = 2'b01;
        bus.s_wlast  = 2'b01;
        bus.m_wready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (bus.m_awvalid && bus.m_awready) begin
                hs2++;
                n_cmp++;
                if (bus.m_awid !== 5'h0A) begin
                    n_bad++;
                    $display("FAIL full_fifth_grant: got awid=%0h want a", bus.m_awid);
                end
            end
            if (bus.s_wready[0] && bus.s_wvalid[0]) popped = 1'b1;
            tick();
            if (popped) bus.s_wvalid = 2'b00;
            if (hs2 > 0) bus.s_awvalid = 2'b00;
        end
        n_cmp++;
        if (hs2 != 1) begin
            n_bad++;
            $display("FAIL full_fifth_count: got %0d handshakes after pop want 1", hs2);
        end
        idle_inputs();
    endtask

    task automatic test_b_routing();
        do_reset();
        bus.m_bvalid = 1'b1;
        bus.m_bid    = 5'h17;
        bus.m_bresp  = 2'b00;
        bus.s_bready = 2'b00;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if ({bus.s_bvalid, bus.s_bid, bus.m_bready} !== {2'b10, 4'h7, 1'b0}) begin
                n_bad++;
                $display("FAIL b_hold%0d: got bvalid=%0b bid=%0h bready=%0b want 10/7/0", c, bus.s_bvalid, bus.s_bid, bus.m_bready);
            end
            tick();
        end
        bus.s_bready = 2'b01;
        #1;
        n_cmp++;
        if (bus.m_bready !== 1'b0) begin
            n_bad++;
            $display("FAIL b_wrong_ready: got bready=%0b want 0", bus.m_bready);
        end
        bus.s_bready = 2'b10;
        #1;
        n_cmp++;
        if (bus.m_bready !== 1'b1) begin
            n_bad++;
            $display("FAIL b_ready: got bready=%0b want 1", bus.m_bready);
        end
        tick();
        bus.m_bid    = 5'h05;
        bus.m_bresp  = 2'b10;
        bus.s_bready = 2'b01;
        #1;
        n_cmp++;
        if ({bus.s_bvalid, bus.s_bid, bus.s_bresp, bus.m_bready} !== {2'b01, 4'h5, 2'b10, 1'b1}) begin
            n_bad++;
            $display("FAIL b_src0: got bvalid=%0b bid=%0h bresp=%0d bready=%0b want 01/5/2/1",
                     bus.s_bvalid, bus.s_bid, bus.s_bresp, bus.m_bready);
        end
        bus.m_bvalid = 1'b0;
        #1;
        n_cmp++;
        if (bus.s_bvalid !== 2'b00) begin
            n_bad++;
            $display("FAIL b_idle: got bvalid=%0b want 00", bus.s_bvalid);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        aw_id[0] = 4'h1; aw_id[1] = 4'h2; aw_len[0] = 4'd1;
        bus.s_awvalid = 2'b01;
        bus.m_awready = 1'b1;
        bus.m_wready  = 1'b1;
        tick();
        tick();
        bus.s_awvalid = 2'b00;
        w_data[0] = DATA_W'(8'h77);
        bus.s_wvalid = 2'b01;
        bus.s_wlast  = 2'b00;
        #1;
        n_cmp++;
        if (bus.m_wvalid !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_beat0: got wvalid=%0b want 1", bus.m_wvalid);
        end
        tick();
        bus.s_wlast = 2'b01;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.m_awvalid, bus.m_wvalid, bus.s_awready, bus.s_wready, bus.aw_state_dbg} !== 7'b0) begin
            n_bad++;
            $display("FAIL rstmid_cleared: got awv=%0b wv=%0b awr=%0b wr=%0b st=%0b want all 0",
                     bus.m_awvalid, bus.m_wvalid, bus.s_awready, bus.s_wready, bus.aw_state_dbg);
        end
        bus.s_wvalid = 2'b00;
        bus.s_wlast  = 2'b00;
        tick();
        rst = 1'b0;
        bus.s_awvalid = 2'b11;
        tick();
        n_cmp++;
        if ({bus.m_awvalid, bus.m_awid} !== {1'b1, 5'h01}) begin
            n_bad++;
            $display("FAIL rstmid_rr_ptr: got awvalid=%0b awid=%0h want 1/01", bus.m_awvalid, bus.m_awid);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_contention();
        test_early_w();
        test_fifo_full();
        test_b_routing();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axi_wr_arbiter.md
# axi_wr_arbiter

Round-robin arbiter that shares the single AXI write path (AW, W, B) into the PCIe block among NUM_REQ independent write requesters. It grants one requester's AW per handshake and tags the outgoing ID with the source index. W beats are steered in AW-grant order through a small order FIFO, and B responses are routed back by the tag. The arbiter sits between the requester AXI write interfaces and the AW/W/B ports of the PCIe block.

## Interface
- NUM_REQ, 2, number of requesters (2..4)
- ID_W, 4, requester-side AXI ID width
- ADDR_W, 32, AXI address width
- DATA_W, 128, AXI data width (strobe width DATA_W/8)
- ORD_DEPTH, 4, W-order FIFO depth (power of 2)
- SRC_W, $clog2(NUM_REQ), derived tag width; master-side ID width is ID_W+SRC_W
- clk  in  1  clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- s_awvalid / s_awready  in / out  NUM_REQ  per-requester AW handshake
- s_awid, s_awaddr  in  NUM_REQ*ID_W, NUM_REQ*ADDR_W  flattened AW fields; requester i at slice i
- s_awlen, s_awsize, s_awburst  in  NUM_REQ*4, NUM_REQ*3, NUM_REQ*2  flattened AW fields
- s_wvalid / s_wready  in / out  NUM_REQ  per-requester W handshake
- s_wdata, s_wstrb, s_wlast  in  NUM_REQ*DATA_W, NUM_REQ*DATA_W/8, NUM_REQ  flattened W fields
- s_bvalid / s_bready  out / in  NUM_REQ  per-requester B handshake
- s_bid, s_bresp  out  ID_W, 2  shared B fields (valid only with the matching s_bvalid)
- m_awvalid / m_awready  out / in  1  master AW handshake
- m_awid  out  ID_W+SRC_W  {src, requester id}
- m_awaddr, m_awlen, m_awsize, m_awburst  out  ADDR_W, 4, 3, 2  muxed AW fields
- m_wvalid / m_wready  out / in  1;  m_wdata, m_wstrb, m_wlast  out  DATA_W, DATA_W/8, 1
- m_bvalid / m_bready  in / out  1;  m_bid  in  ID_W+SRC_W;  m_bresp  in  2

## Operation
- AW FSM states:
  - IDLE: if any s_awvalid and the order FIFO is not full, pick the first valid index at or after rr_ptr (wrapping), register it as grant, and go to GRANT. Otherwise stay.
  - GRANT: m_awvalid = s_awvalid[grant]. All m_aw* fields come from slice grant. m_awid = {grant, s_awid[grant]}. s_awready[grant] = m_awready. All other s_awready = 0.
  - On the m_awvalid && m_awready handshake: push grant into the order FIFO, set rr_ptr = grant+1 (mod NUM_REQ), and return to IDLE.
- The grant is held until its handshake completes. It is never revoked while m_awvalid is high (AXI stability rule).
- W steering, with head = order FIFO head:
  - m_wvalid = !empty && s_wvalid[head]; m_w* fields come from slice head.
  - s_wready[head] = !empty && m_wready. All other s_wready = 0.
  - Pop on a W handshake with s_wlast[head] = 1.
  - With the FIFO empty, all s_wready = 0 and m_wvalid = 0. W beats that arrive early simply stall.
- B routing: src = m_bid[ID_W+SRC_W-1:ID_W].
  - s_bvalid[src] = m_bvalid; m_bready = s_bready[src].
  - s_bid = m_bid[ID_W-1:0]; s_bresp = m_bresp. Purely combinational.
  - If src >= NUM_REQ (NUM_REQ = 3 only): m_bready = 1 and the response is dropped.
- FIFO push and pop in the same cycle are both performed. Count is unchanged, and this is legal even when the FIFO is full.

## Timing
- Reset values: state = IDLE, rr_ptr = 0, FIFO empty, m_awvalid = 0, m_wvalid = 0, all s_awready = 0, all s_wready = 0. s_bvalid follows m_bvalid, so it is 0 while the PCIe block is in reset.
- AW latency: s_awvalid at cycle N gives m_awvalid at N+1 (registered grant), with zero added cycles after that.
- AW throughput: at most one grant every 2 cycles (IDLE→GRANT→IDLE).
- W and B paths have zero latency (combinational mux). A W beat may pass in the same cycle as the AW handshake's push only on the following cycle: the pushed entry is visible at N+1.
- Asserting rst mid-burst clears the FIFO and FSM immediately. Outstanding B responses are not tracked and the system must be reset as a whole.

## Test plan
- Single requester: req0 writes 32B to address 0x0 (awlen = 1, size 128b, two beats of 0x01234567 pattern) → m_awid = {0,0}, two W beats in order with m_wlast on the second, B bresp 0 returned on s_bvalid[0] only.
- Contention: req0 and req1 assert AW in the same cycle from reset → grant order 0, 1, 0, 1 over 4 bursts. W beats on m_w* exactly follow that order.
- Early W: req1 drives wvalid 5 cycles before its awvalid → s_wready[1] stays 0 until 1 cycle after its AW handshake, and no beat leaks.
- Order FIFO full: m_wready held 0 while 5 AWs are offered → exactly 4 AW handshakes, the 5th is held until the first wlast pop, then granted.
- B routing: m_bid = {1,4'h7} with bresp 2'b00 → s_bvalid = 2'b10, s_bid = 7. m_bready mirrors s_bready[1], held low for 3 cycles.
- Reset mid-operation: rst pulsed between the two W beats of a burst → all outputs return to reset values within the same cycle, and the next AW is granted from rr_ptr = 0.
